mipi_payload_assembler: RTL and testbench

- Byte-serial front end that sits directly upstream of the pixel data generator.
- Collects result/telemetry bytes from the miner core into one DLEN-byte payload word.
- Hands the payload to the generator with a one-cycle write_enable pulse, but only when the generator reports not busy.
- Waits for the generator to acknowledge by raising busy, then frees the buffer for the next payload.

---
 rtl/mipi_payload_assembler.sv | 110 +++++++++++
 tb/tb_mipi_payload_assembler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_payload_assembler.sv
// mipi_payload_assembler: packs a byte stream from the miner core into one DLEN-byte
//   payload and hands it to the pixel data generator with a one-cycle write_enable,
//   launching only while busy is low, then frees the buffer once busy acknowledges.
// Latency: last byte accepted on N -> held on N+1 -> write_enable on N+2 if busy is low.
// Backpressure: in_ready is high only while filling; it stays low from payload
//   completion until busy is seen high after the launch.
// Ports: tx_pixel_clk, reset (async, active-high); in_data/in_valid/in_last/in_ready
//   byte stream; busy from the generator; data_out (byte i at [8i+7:8i]),
//   write_enable, payload_bytes, launch_count.
// Optional: define MIPI_ASM_ACK_TIMEOUT_EN to re-launch the held payload when busy
//   has not risen within ACK_TIMEOUT cycles of a launch.
module mipi_payload_assembler #(
   parameter int DLEN        = 43,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic              tx_pixel_clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              busy,
   output logic [DLEN*8-1:0] data_out,
   output logic              write_enable,
   output logic [15:0]       payload_bytes,
   output logic [15:0]       launch_count
);

   localparam int IW = $clog2(DLEN + 1);

   typedef enum logic [1:0] {FILL, HOLD, LAUNCH, ACK} state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic          accept;

   assign in_ready = (state == FILL);
   assign accept   = in_valid && in_ready;

`ifdef MIPI_ASM_ACK_TIMEOUT_EN
   logic [15:0] wait_cnt;
`else
   // ACK_TIMEOUT only matters when the retry feature is built in.
   logic unused_ack_timeout;
   assign unused_ack_timeout = ^ACK_TIMEOUT;
`endif

   always_ff @(posedge tx_pixel_clk or posedge reset) begin
      if (reset) begin
         state         <= FILL;
         idx           <= '0;
         data_out      <= '0;
         write_enable  <= 1'b0;
         payload_bytes <= '0;
         launch_count  <= '0;
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         write_enable <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  for (int i = 0; i < DLEN; i++) begin
                     if (idx == IW'(i)) data_out[8*i +: 8] <= in_data;
                  end
                  idx <= idx + 1'b1;
                  // A full buffer and an explicit in_last end the payload identically.
                  if (idx == IW'(DLEN - 1) || in_last) begin
                     payload_bytes <= 16'(idx) + 16'd1;
                     state         <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!busy) begin
                  write_enable <= 1'b1;
                  state        <= LAUNCH;
               end
            end
            LAUNCH: begin
               // The generator copies data_out on the strobe cycle itself.
               state <= ACK;
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ACK: begin
               if (busy) begin
                  // Generator owns its copy now, so the buffer can be wiped; the
                  // clear keeps the unused top bytes of a short payload at zero.
                  launch_count <= launch_count + 16'd1;
                  data_out     <= '0;
                  idx          <= '0;
                  state        <= FILL;
               end
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
               else if (wait_cnt == 16'(ACK_TIMEOUT - 1)) begin
                  state <= HOLD;  // payload kept intact for the retry
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_mipi_payload_assembler.sv
// tb_mipi_payload_assembler: directed scenarios with literal expectations followed by
//   randomized traffic, all compared every cycle against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_mipi_payload_assembler;
   localparam int DLEN = 43;
   localparam int TMO  = 16;
   localparam int DW   = DLEN * 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   wire           busy;
   logic          busy_force = 1'b0;
   logic          busy_gen = 1'b0;
   logic          rand_mode = 1'b0;
   logic [DW-1:0] data_out;
   logic          write_enable;
   logic [15:0]   payload_bytes;
   logic [15:0]   launch_count;

   int checks = 0;
   int errors = 0;

   assign busy = rand_mode ? busy_gen : busy_force;

   always #5 clk = ~clk;

   mipi_payload_assembler #(.DLEN(DLEN), .ACK_TIMEOUT(TMO)) dut (
      .tx_pixel_clk (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .busy         (busy),
      .data_out     (data_out),
      .write_enable (write_enable),
      .payload_bytes(payload_bytes),
      .launch_count (launch_count)
   );

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases of a payload's life: collecting bytes, complete and waiting for the
   // generator to be idle, being offered (strobe cycle), waiting for the acknowledge.
   localparam int COLLECT = 0, WAIT_IDLE = 1, OFFER = 2, WAIT_ACK = 3;
   int          ph = COLLECT;
   int          cnt = 0;
   int          waited = 0;
   logic [7:0]  mb [DLEN] = '{default: 8'h00};
   logic [15:0] m_pb = 16'd0;
   logic [15:0] m_lc = 16'd0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ph = COLLECT; cnt = 0; m_pb = 16'd0; m_lc = 16'd0;
         foreach (mb[i]) mb[i] = 8'h00;
      end else begin
         case (ph)
            COLLECT: if (in_valid) begin
               mb[cnt] = in_data;
               cnt++;
               if (cnt == DLEN || in_last) begin
                  m_pb = 16'(cnt);
                  ph = WAIT_IDLE;
               end
            end
            WAIT_IDLE: if (!busy) ph = OFFER;
            OFFER: begin ph = WAIT_ACK; waited = 0; end
            default: begin
               if (busy) begin
                  m_lc++;
                  foreach (mb[i]) mb[i] = 8'h00;
                  cnt = 0;
                  ph = COLLECT;
               end
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
               else begin
                  waited++;
                  if (waited == TMO) ph = WAIT_IDLE;
               end
`endif
            end
         endcase
      end
   end

   function automatic logic [DW-1:0] model_data();
      logic [DW-1:0] v = '0;
      for (int i = 0; i < DLEN; i++) v[8*i +: 8] = mb[i];
      return v;
   endfunction

   always @(negedge clk) begin
      chk("m_in_ready", DW'(in_ready), DW'(ph == COLLECT));
      chk("m_write_enable", DW'(write_enable), DW'(ph == OFFER));
      chk("m_data_out", data_out, model_data());
      chk("m_payload_bytes", DW'(payload_bytes), DW'(m_pb));
      chk("m_launch_count", DW'(launch_count), DW'(m_lc));
   end

   // Random-mode generator: acknowledges each strobe after a short random delay,
   // plus occasional spurious busy pulses so busy toggles while a payload is held.
   int ack_dly = 0, ack_hold = 0;
   always @(negedge clk) begin
      if (write_enable) ack_dly = $urandom_range(1, 4);
      else if (ack_dly > 0) begin
         ack_dly--;
         if (ack_dly == 0) ack_hold = $urandom_range(1, 5);
      end else if (ack_hold > 0) ack_hold--;
      busy_gen = ($urandom_range(0, 7) == 0) || (ack_dly == 0 && ack_hold > 0);
   end

   // ---------------- directed + random stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      in_valid = 1'b1; in_data = d; in_last = last;
      step();
   endtask

   // Called on the strobe cycle's falling edge: busy rises the cycle after the strobe.
   task automatic ack();
      step(); busy_force = 1'b1;
      step(); step(); busy_force = 1'b0;
   endtask

   logic [DW-1:0] expv;
   logic [15:0]   lc_before;
   int            bad, pulses, first_p, second_p;

   initial begin
      // Reset state
      step(); step();
      @(negedge clk);
      chk("rst_in_ready", DW'(in_ready), DW'(1'b1));
      chk("rst_write_enable", DW'(write_enable), '0);
      chk("rst_data_out", data_out, '0);
      chk("rst_payload_bytes", DW'(payload_bytes), '0);
      chk("rst_launch_count", DW'(launch_count), '0);
      reset = 1'b0;
      step();

      // 1. Full payload 0x00..0x2A; 4. byte 0x77 presented while back-pressured
      for (int b = 0; b < DLEN; b++) send(8'(b), 1'b0);
      in_data = 8'h77; in_last = 1'b1;
      @(negedge clk);
      chk("t1_ready_low", DW'(in_ready), '0);
      chk("t1_no_early_we", DW'(write_enable), '0);
      step(); @(negedge clk);
      chk("t1_we", DW'(write_enable), DW'(1'b1));
      chk("t1_byte0", DW'(data_out[7:0]), DW'(8'h00));
      chk("t1_byte42", DW'(data_out[343:336]), DW'(8'h2A));
      chk("t1_pb", DW'(payload_bytes), DW'(16'd43));
      step(); busy_force = 1'b1;
      @(negedge clk);
      chk("t1_we_one_cycle", DW'(write_enable), '0);
      chk("t1_ready_in_ack", DW'(in_ready), '0);
      step(); busy_force = 1'b0;
      @(negedge clk);
      chk("t1_lc", DW'(launch_count), DW'(16'd1));
      chk("t1_ready_again", DW'(in_ready), DW'(1'b1));
      chk("t1_cleared", data_out, '0);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("t4_held", DW'(in_ready), '0);
      step(); @(negedge clk);
      chk("t4_we", DW'(write_enable), DW'(1'b1));
      chk("t4_pb_min", DW'(payload_bytes), DW'(16'd1));
      chk("t4_data", data_out, DW'(8'h77));
      ack();

      // 2. Short payload
      for (int b = 0; b < 5; b++) send(8'hA1 + 8'(b), b == 4);
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("t2_ready_low", DW'(in_ready), '0);
      step(); @(negedge clk);
      chk("t2_we", DW'(write_enable), DW'(1'b1));
      chk("t2_pb", DW'(payload_bytes), DW'(16'd5));
      chk("t2_data", data_out, DW'(40'hA5A4A3A2A1));
      chk("t2_lc", DW'(launch_count), DW'(16'd2));
      ack();

      // 3. Busy hold-off for 200 cycles
      busy_force = 1'b1;
      expv = '0;
      for (int b = 0; b < DLEN; b++) begin
         expv[8*b +: 8] = 8'($urandom);
         send(expv[8*b +: 8], 1'b0);
      end
      in_valid = 1'b0;
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (write_enable !== 1'b0 || in_ready !== 1'b0) bad++;
         step();
      end
      chk("t3_quiet_while_busy", DW'(bad), '0);
      busy_force = 1'b0;
      @(negedge clk);
      chk("t3_not_yet", DW'(write_enable), '0);
      step(); @(negedge clk);
      chk("t3_we", DW'(write_enable), DW'(1'b1));
      chk("t3_data", data_out, expv);
      step(); @(negedge clk);
      chk("t3_single", DW'(write_enable), '0);
      step(); busy_force = 1'b1;
      step(); step(); busy_force = 1'b0;

      // 5. Reset mid-fill
      for (int b = 0; b < 20; b++) send(8'($urandom_range(1, 255)), 1'b0);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("t5_data_cleared", data_out, '0);
      chk("t5_ready", DW'(in_ready), DW'(1'b1));
      chk("t5_lc_reset", DW'(launch_count), '0);
      reset = 1'b0;
      step();
      expv = '0;
      for (int b = 0; b < DLEN; b++) begin
         expv[8*b +: 8] = 8'($urandom);
         send(expv[8*b +: 8], 1'b0);
      end
      in_valid = 1'b0;
      step(); @(negedge clk);
      chk("t5_we", DW'(write_enable), DW'(1'b1));
      chk("t5_clean_payload", data_out, expv);
      chk("t5_pb", DW'(payload_bytes), DW'(16'd43));
      ack();

      // 6. No acknowledge from the generator
      lc_before = launch_count;
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      pulses = 0; first_p = -1; second_p = -1;
      for (int j = 0; j < 60; j++) begin
         @(negedge clk);
         if (write_enable === 1'b1) begin
            pulses++;
            if (first_p < 0) first_p = j;
            else if (second_p < 0) second_p = j;
         end
         step();
      end
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
      chk("t6_retry_period", DW'(second_p - first_p), DW'(TMO + 2));
`else
      chk("t6_single_pulse", DW'(pulses), DW'(1));
`endif
      @(negedge clk);
      chk("t6_lc_flat", DW'(launch_count), DW'(lc_before));
      chk("t6_data_kept", data_out, DW'(24'h332211));
`ifdef MIPI_ASM_ACK_TIMEOUT_EN
      bad = 1;
      for (int j = 0; j < 3 * TMO && bad != 0; j++) begin
         if (write_enable === 1'b1) bad = 0;
         else begin step(); @(negedge clk); end
      end
      chk("t6_retry_seen", DW'(bad), '0);
`endif
      ack();

      // Randomized traffic with random busy and occasional resets
      rand_mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         in_last  = ($urandom_range(0, 11) == 0);
         reset    = ($urandom_range(0, 399) == 0);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; reset = 1'b0;
      step(); step();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
